// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
//   AXI4-Lite slave in front of a small word-addressed register file.
//   Read and write paths are independent FSMs that never stall each other.
//   Out-of-range accesses (address >= DEPTH) answer SLVERR: reads return 0 and
//   writes leave storage untouched. Partial writes honour W_STRB per byte.
//
// Ports
//   s_clk, rst                    : clock, asynchronous active-high reset
//   read_address/AR_VALID/AR_READY: read address channel
//   data_read/R_RESP/R_VALID/R_READY : read data channel
//   write_address/AW_VALID/AW_READY  : write address channel
//   write_data/W_STRB/W_VALID/W_READY: write data channel
//   BRESPONSE/B_VALID/B_READY     : write response channel
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                s_clk,
  input  logic                rst,
  // read address channel
  input  logic [ADDR_W-1:0]   read_address,
  input  logic                AR_VALID,
  output logic                AR_READY,
  // read data channel
  output logic [DATA_W-1:0]   data_read,
  output logic [1:0]          R_RESP,
  output logic                R_VALID,
  input  logic                R_READY,
  // write address channel
  input  logic [ADDR_W-1:0]   write_address,
  input  logic                AW_VALID,
  output logic                AW_READY,
  // write data channel
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] W_STRB,
  input  logic                W_VALID,
  output logic                W_READY,
  // write response channel
  output logic [1:0]          BRESPONSE,
  output logic                B_VALID,
  input  logic                B_READY
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;

  rstate_t             r_rstate;
  wstate_t             r_wstate;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;

  logic                w_ar_hs;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_rd_in_range;
  logic                w_wr_in_range;
  logic                w_commit;
  logic [ADDR_W-1:0]   w_commit_addr;
  logic [DATA_W-1:0]   w_commit_data;
  logic [STRB_W-1:0]   w_commit_strb;

  assign w_ar_hs       = AR_VALID & AR_READY;
  assign w_aw_hs       = AW_VALID & AW_READY;
  assign w_w_hs        = W_VALID  & W_READY;
  assign w_rd_in_range = {1'b0, read_address}  < DEPTH_L;
  assign w_wr_in_range = {1'b0, w_commit_addr} < DEPTH_L;

  // ---------------------------------------------------------------------------
  // Read FSM. Storage is sampled on the AR edge, so a write committing on the
  // same edge is not yet visible: the read returns the pre-write word.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      AR_READY  <= 1'b1;
      R_VALID   <= 1'b0;
      data_read <= '0;
      R_RESP    <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            data_read <= w_rd_in_range ? r_mem[read_address] : '0;
            R_RESP    <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            R_VALID   <= 1'b1;
            AR_READY  <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (R_READY) begin
            R_VALID  <= 1'b0;
            AR_READY <= 1'b1;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write commit: fires on the edge that completes the AW/W pair, taking each
  // half either from this cycle's channel or from what was latched earlier.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_commit      = 1'b0;
    w_commit_addr = r_waddr;
    w_commit_data = r_wdata;
    w_commit_strb = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit      = 1'b1;
          w_commit_addr = write_address;
          w_commit_data = write_data;
          w_commit_strb = W_STRB;
        end
      end
      W_HAVE_ADDR: begin
        if (w_w_hs) begin
          w_commit      = 1'b1;
          w_commit_data = write_data;
          w_commit_strb = W_STRB;
        end
      end
      W_HAVE_DATA: begin
        if (w_aw_hs) begin
          w_commit      = 1'b1;
          w_commit_addr = write_address;
        end
      end
      default: ;
    endcase
  end

  // Write FSM. Partially captured halves are simply dropped by reset.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      AW_READY  <= 1'b1;
      W_READY   <= 1'b1;
      B_VALID   <= 1'b0;
      BRESPONSE <= RESP_OKAY;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_commit) begin
      r_wstate  <= W_RESP;
      AW_READY  <= 1'b0;
      W_READY   <= 1'b0;
      B_VALID   <= 1'b1;
      BRESPONSE <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_waddr  <= write_address;
            AW_READY <= 1'b0;
            r_wstate <= W_HAVE_ADDR;
          end else if (w_w_hs) begin
            r_wdata  <= write_data;
            r_wstrb  <= W_STRB;
            W_READY  <= 1'b0;
            r_wstate <= W_HAVE_DATA;
          end
        end
        W_RESP: begin
          if (B_READY) begin
            B_VALID  <= 1'b0;
            AW_READY <= 1'b1;
            W_READY  <= 1'b1;
            r_wstate <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage with byte-lane write enables.
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is reset explicitly because reset must clear every
  // word; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit && w_wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_commit_strb[b]) r_mem[w_commit_addr][8*b +: 8] <= w_commit_data[8*b +: 8];
      end
    end
  end

endmodule
